// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode loader and the microcoded FSM that consumes its tables.
package microcode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CS,
        ST_D1,
        ST_D2,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] SEL_CS = 2'd0;
    localparam logic [1:0] SEL_D1 = 2'd1;
    localparam logic [1:0] SEL_D2 = 2'd2;

    localparam logic [7:0] HDR_DEFAULT  = 8'hA5;
    localparam int         CS_DEPTH_DEF = 16;
    localparam int         DT_DEPTH_DEF = 4;

endpackage

// File: rtl/ucode_sum_acc.sv
// 8-bit modulo-256 accumulator; match compares the running sum against the current byte.
module ucode_sum_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] data,
    output logic       match
);

    logic [7:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sum <= 8'd0;
        else if (clr)    sum <= 8'd0;
        else if (add_en) sum <= sum + data;
    end

    assign match = (sum == data);

endmodule

// File: rtl/microcode_loader.sv
// Streams a framed, checksummed image into the control store and both dispatch tables.
module microcode_loader
    import microcode_pkg::*;
#(
    parameter logic [7:0] HDR      = HDR_DEFAULT,
    parameter int         CS_DEPTH = CS_DEPTH_DEF,
    parameter int         DT_DEPTH = DT_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       wr_en,
    output logic [1:0] wr_sel,
    output logic [3:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       table_valid
);

    localparam logic [3:0] CS_LAST = 4'(CS_DEPTH - 1);
    localparam logic [3:0] DT_LAST = 4'(DT_DEPTH - 1);

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    logic       accept;
    logic       sum_clr, sum_add, sum_match;
    logic       wr_en_n, done_n, err_n, tv_n;
    logic [1:0] wr_sel_n;
    logic [3:0] wr_addr_n, wr_data_n;

    assign s_ready = (state inside {ST_HDR, ST_CS, ST_D1, ST_D2, ST_CHK});
    assign busy    = s_ready;
    assign accept  = s_valid & s_ready;

    ucode_sum_acc u_sum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (sum_clr),
        .add_en (sum_add),
        .data   (s_data),
        .match  (sum_match)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        wr_en_n   = 1'b0;
        wr_sel_n  = wr_sel;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        done_n    = 1'b0;
        err_n     = err;
        tv_n      = table_valid;
        sum_clr   = 1'b0;
        sum_add   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n = ST_HDR;
                    err_n   = 1'b0;
                    tv_n    = 1'b0;
                    idx_n   = 4'd0;
                    sum_clr = 1'b1;
                end
            end
            ST_HDR: begin
                if (accept && s_data == HDR) state_n = ST_CS;
            end
            ST_CS: begin
                if (accept) begin
                    // Reserved bits set: abort before the byte touches the store or the sum.
                    if (|s_data[7:3]) begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_sel_n  = SEL_CS;
                        wr_addr_n = idx;
                        wr_data_n = {1'b0, s_data[2:0]};
                        sum_add   = 1'b1;
                        idx_n     = (idx == CS_LAST) ? 4'd0 : idx + 4'd1;
                        if (idx == CS_LAST) state_n = ST_D1;
                    end
                end
            end
            ST_D1, ST_D2: begin
                if (accept) begin
                    if (|s_data[7:4]) begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_sel_n  = (state == ST_D1) ? SEL_D1 : SEL_D2;
                        wr_addr_n = idx;
                        wr_data_n = s_data[3:0];
                        sum_add   = 1'b1;
                        idx_n     = (idx == DT_LAST) ? 4'd0 : idx + 4'd1;
                        if (idx == DT_LAST) state_n = (state == ST_D1) ? ST_D2 : ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (sum_match) begin
                        state_n = ST_DONE;
                        tv_n    = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 4'd0;
            wr_en       <= 1'b0;
            wr_sel      <= 2'd0;
            wr_addr     <= 4'd0;
            wr_data     <= 4'd0;
            done        <= 1'b0;
            err         <= 1'b0;
            table_valid <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            wr_en       <= wr_en_n;
            wr_sel      <= wr_sel_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            done        <= done_n;
            err         <= err_n;
            table_valid <= tv_n;
        end
    end

endmodule

// File: tb/tb_microcode_loader.sv
// Randomized bench for microcode_loader against an image-level reference model.
module tb_microcode_loader;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_ready, wr_en, busy, done, err, table_valid;
    logic [1:0] wr_sel;
    logic [3:0] wr_addr, wr_data;

    microcode_loader #(.HDR(8'hA5), .CS_DEPTH(16), .DT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err), .table_valid(table_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;

    typedef struct {
        int         due;
        logic [1:0] sel;
        logic [3:0] addr;
        logic [3:0] data;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t        exp_q[$];
    bit         m_loading = 0, m_hdr = 0, m_err = 0, m_tv = 0;
    int         m_n = 0, m_start_edge = 0, exp_done_cyc = -1;
    logic [7:0] m_sum = 8'd0;
    int         done_cnt = 0, done_at = -1, wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic void model_start(input int edge_k);
        m_loading = 1; m_hdr = 0; m_n = 0; m_sum = 8'd0; m_err = 0; m_tv = 0;
        m_start_edge = edge_k;
    endfunction

    function automatic void model_reset();
        m_loading = 0; m_err = 0; m_tv = 0; exp_done_cyc = -1;
        exp_q.delete();
    endfunction

    // Payload index 0..15 is the control store, 16..19 dispatch 1, 20..23 dispatch 2.
    function automatic void model_accept(input logic [7:0] b, input int edge_k);
        wr_t w;
        int  lim;
        if (!m_hdr) begin
            if (b == 8'hA5) m_hdr = 1;
        end else if (m_n < 24) begin
            lim = (m_n < 16) ? 8 : 16;
            if (int'(b) >= lim) begin
                m_err = 1; m_loading = 0;
            end else begin
                w.due  = edge_k + 1;
                w.sel  = (m_n < 16) ? 2'd0 : (m_n < 20) ? 2'd1 : 2'd2;
                w.addr = 4'((m_n < 16) ? m_n : (m_n < 20) ? m_n - 16 : m_n - 20);
                w.data = b[3:0];
                exp_q.push_back(w);
                m_sum = m_sum + b;
                m_n++;
            end
        end else begin
            m_loading = 0;
            if (b == m_sum) begin
                m_tv = 1; exp_done_cyc = edge_k + 1;
            end else begin
                m_err = 1;
            end
        end
    endfunction

    // One clock: drive inputs, resolve handshake, then advance the model at the edge.
    task automatic step(input logic st, input logic v, input logic [7:0] d, output bit acc);
        start = st; s_valid = v; s_data = d;
        @(negedge clk);
        acc = v && s_ready;
        @(posedge clk);
        if (st && !m_loading) model_start(cyc);
        else if (acc) model_accept(d, cyc);
        #1;
    endtask

    task automatic load(input bq_t img, input int gap_pct, input int mid_start_at);
        bit acc;
        bit v;
        int k;
        k = 0;
        done_cnt = 0; wr_cnt = 0; done_at = -1;
        step(1'b1, 1'b0, 8'd0, acc);
        while (img.size() > 0 && m_loading && k < 2000) begin
            v = ($urandom_range(99) >= gap_pct);
            step(k == mid_start_at, v, img[0], acc);
            if (acc) void'(img.pop_front());
            k++;
        end
        if (k >= 2000) fail_now("load_cycle_budget");
        repeat (3) step(1'b0, 1'b0, 8'd0, acc);
    endtask

    function automatic bq_t make_image(input logic [7:0] cs_byte, input bit bad_cs);
        bq_t        q;
        logic [7:0] s;
        s = 8'd0;
        q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin q.push_back(cs_byte); s = s + cs_byte; end
        for (int i = 1; i <= 8; i++) begin q.push_back(8'(i)); s = s + 8'(i); end
        q.push_back(bad_cs ? s + 8'd1 : s);
        return q;
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        wr_t w;
        if (!rst_n) begin
            check("rst_s_ready", s_ready, 0);
            check("rst_wr_en", wr_en, 0);
            check("rst_wr_sel", wr_sel, 0);
            check("rst_wr_addr", wr_addr, 0);
            check("rst_wr_data", wr_data, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_table_valid", table_valid, 0);
        end else begin
            check("s_ready", s_ready, m_loading);
            check("busy", busy, m_loading);
            check("err", err, m_err);
            check("table_valid", table_valid, m_tv);
            check("done", done, cyc == exp_done_cyc);
            if (done) begin done_cnt++; done_at = cyc; end
            if (wr_en && done) fail_now("write_and_done_overlap");
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    w = exp_q.pop_front();
                    check("wr_cycle", cyc, w.due);
                    check("wr_sel", wr_sel, w.sel);
                    check("wr_addr", wr_addr, w.addr);
                    check("wr_data", wr_data, w.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                fail_now("missing_write");
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit  acc;
        bq_t img;
        int  kind, junk, bad_idx;
        logic [7:0] s;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 8'd0, acc);

        // Clean load with s_valid held high
        load(make_image(8'h01, 0), 0, -1);
        check("clean_sum_literal", m_sum, 8'h34);
        check("clean_done_cnt", done_cnt, 1);
        check("clean_done_at", done_at, m_start_edge + 27);
        check("clean_writes", wr_cnt, 24);
        check("clean_table_valid", table_valid, 1);
        check("clean_err", err, 0);

        // Bad checksum 35
        img = make_image(8'h01, 1);
        check("bad_cs_literal", img[25], 8'h35);
        load(img, 0, -1);
        check("badcs_done_cnt", done_cnt, 0);
        check("badcs_err", err, 1);
        check("badcs_table_valid", table_valid, 0);
        check("badcs_writes", wr_cnt, 24);

        // Resync: 00 FF discarded ahead of the header
        img = make_image(8'h01, 0);
        img.push_front(8'hFF);
        img.push_front(8'h00);
        load(img, 0, -1);
        check("resync_done_cnt", done_cnt, 1);
        check("resync_done_at", done_at, m_start_edge + 29);
        check("resync_table_valid", table_valid, 1);

        // Reserved bits in CS index 5
        img = make_image(8'h01, 0);
        img[6] = 8'h09;
        load(img, 0, -1);
        check("rsvd_writes", wr_cnt, 5);
        check("rsvd_err", err, 1);
        check("rsvd_s_ready", s_ready, 0);
        check("rsvd_done_cnt", done_cnt, 0);

        // Stalls and a start pulse mid-load
        load(make_image(8'h01, 0), 50, 10);
        check("stall_done_cnt", done_cnt, 1);
        check("stall_writes", wr_cnt, 24);
        check("stall_table_valid", table_valid, 1);

        // Reset during D1, then a full reload
        img = make_image(8'h02, 0);
        step(1'b1, 1'b0, 8'd0, acc);
        for (int k = 0; k < 200 && m_n < 18; k++) begin
            step(1'b0, 1'b1, img[0], acc);
            if (acc) void'(img.pop_front());
        end
        check("reset_reached_d1", m_n, 18);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy_after", busy, 0);
        check("reset_tv_after", table_valid, 0);
        load(make_image(8'h02, 0), 0, -1);
        check("reload_done_cnt", done_cnt, 1);
        check("reload_table_valid", table_valid, 1);

        // Randomized images: 0 good, 1 bad checksum, 2 reserved-bit violation
        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(2);
            junk = $urandom_range(3);
            img.delete();
            s = 8'd0;
            for (int j = 0; j < junk; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom_range(255));
                img.push_back(jb == 8'hA5 ? 8'h00 : jb);
            end
            img.push_back(8'hA5);
            for (int j = 0; j < 24; j++) begin
                logic [7:0] pb;
                pb = 8'($urandom_range(j < 16 ? 7 : 15));
                img.push_back(pb);
                s = s + pb;
            end
            img.push_back(kind == 1 ? s ^ 8'h5A : s);
            bad_idx = $urandom_range(23);
            if (kind == 2) img[junk + 1 + bad_idx] = (bad_idx < 16) ? 8'h48 : 8'h90;
            load(img, $urandom_range(60), $urandom_range(40));
            check("rand_done_cnt", done_cnt, kind == 0);
            check("rand_err", err, kind != 0);
            check("rand_writes", wr_cnt, kind == 2 ? bad_idx : 24);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
